// File: rtl/posit_resp_buffer.sv
// Credit-gated in-order result FIFO between a requester and the posit unit; 1-cycle push-to-resp latency.
// Backpressure: issue stalls at zero credits; unit_ready_o drops only when storage is full; flush drops all state.
module posit_resp_buffer #(
  parameter int Width    = 32,
  parameter int Depth    = 4,
  parameter int TagWidth = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  output logic                      unit_in_valid_o,
  input  logic                      unit_in_ready_i,
  input  logic                      unit_valid_i,
  output logic                      unit_ready_o,
  input  logic [Width-1:0]          unit_result_i,
  input  logic [4:0]                unit_status_i,
  input  logic [TagWidth-1:0]       unit_tag_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [Width-1:0]          resp_result_o,
  output logic [4:0]                resp_status_o,
  output logic [TagWidth-1:0]       resp_tag_o,
  output logic [$clog2(Depth):0]    credits_o,
  output logic                      busy_o,
  output logic                      overflow_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef struct packed {
    logic [Width-1:0]    result;
    logic [4:0]          status;
    logic [TagWidth-1:0] tag;
  } entry_t;

  entry_t          mem [Depth];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [CntW-1:0] outstanding;
  logic [CntW-1:0] credits;
  logic            has_credit;
  logic            issue;
  logic            result_hs;
  logic            push;
  logic            pop;

  // Every issued op reserves a slot until its result is popped.
  assign credits    = DepthC - count - outstanding;
  assign has_credit = (credits != '0);

  assign unit_in_valid_o = req_valid_i & has_credit & ~flush_i;
  assign req_ready_o     = unit_in_ready_i & has_credit & ~flush_i;
  assign issue           = unit_in_valid_o & unit_in_ready_i;

  assign unit_ready_o = (count != DepthC);
  assign result_hs    = unit_valid_i & unit_ready_o;
  assign push         = result_hs & ~flush_i;
  assign pop          = resp_valid_o & resp_ready_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CntOne;
    end else if (pop && !push) begin
      count <= count - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else if (flush_i) begin
      outstanding <= '0;
    end else if (issue && !result_hs) begin
      outstanding <= outstanding + CntOne;
    end else if (result_hs && !issue && outstanding != '0) begin
      outstanding <= outstanding - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // Storage is cleared on reset so resp_* read as zero before the first push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{result: unit_result_i, status: unit_status_i, tag: unit_tag_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (unit_valid_i && count == DepthC && outstanding == '0) begin
      overflow_o <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign resp_valid_o  = (count != '0);
  assign resp_result_o = head.result;
  assign resp_status_o = head.status;
  assign resp_tag_o    = head.tag;
  assign credits_o     = credits;
  assign busy_o        = (outstanding != '0) | (count != '0);

endmodule

// File: tb/tb_posit_resp_buffer.sv
// Directed bench for posit_resp_buffer: queue-based reference model checked every cycle plus literal pins.
module tb_posit_resp_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        unit_in_valid_o;
  logic        unit_in_ready_i;
  logic        unit_valid_i;
  logic        unit_ready_o;
  logic [31:0] unit_result_i;
  logic [4:0]  unit_status_i;
  logic [0:0]  unit_tag_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_result_o;
  logic [4:0]  resp_status_o;
  logic [0:0]  resp_tag_o;
  logic [2:0]  credits_o;
  logic        busy_o;
  logic        overflow_o;

  posit_resp_buffer #(.Width(32), .Depth(4), .TagWidth(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .unit_in_valid_o(unit_in_valid_o), .unit_in_ready_i(unit_in_ready_i),
    .unit_valid_i(unit_valid_i), .unit_ready_o(unit_ready_o),
    .unit_result_i(unit_result_i), .unit_status_i(unit_status_i), .unit_tag_i(unit_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_status_o(resp_status_o), .resp_tag_o(resp_tag_o),
    .credits_o(credits_o), .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  s;
    logic        t;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  int   m_out = 0;
  bit   m_ovf = 0;
  logic [31:0] popped_r[$];
  logic        popped_t[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: outputs follow from a queue of stored results plus an in-flight count.
  always @(negedge clk_i) begin
    int  sz;
    int  cr;
    bit  ok;
    if (!rst_ni) begin
      mq.delete();
      m_out = 0;
      m_ovf = 0;
    end else begin
      sz = mq.size();
      cr = 4 - sz - m_out;
      ok = (cr != 0) && !flush_i;
      chk("credits", credits_o, cr);
      chk("req_ready", req_ready_o, unit_in_ready_i && ok);
      chk("unit_in_valid", unit_in_valid_o, req_valid_i && ok);
      chk("unit_ready", unit_ready_o, sz != 4);
      chk("resp_valid", resp_valid_o, sz != 0);
      chk("busy", busy_o, (sz != 0) || (m_out != 0));
      chk("overflow", overflow_o, m_ovf);
      if (sz != 0) begin
        chk("resp_result", resp_result_o, mq[0].r);
        chk("resp_status", resp_status_o, mq[0].s);
        chk("resp_tag", resp_tag_o, mq[0].t);
      end
      if (unit_valid_i && sz == 4 && m_out == 0) m_ovf = 1;
      if (flush_i) begin
        mq.delete();
        m_out = 0;
      end else begin
        if (req_valid_i && unit_in_ready_i && cr != 0) m_out++;
        if (sz != 0 && resp_ready_i) begin
          popped_r.push_back(mq[0].r);
          popped_t.push_back(mq[0].t);
          void'(mq.pop_front());
        end
        if (unit_valid_i && sz != 4) begin
          if (m_out > 0) m_out--;
          mq.push_back('{r: unit_result_i, s: unit_status_i, t: unit_tag_i[0]});
        end
      end
    end
  end

  logic [31:0] exp_r [16];
  logic        exp_t [16];
  int issued, returned, cyc;
  bit iss_flag, ret_flag;

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b1; unit_in_ready_i = 1'b1;
    unit_valid_i = 1'b0; unit_result_i = '0; unit_status_i = '0; unit_tag_i = '0;
    resp_ready_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_credits", credits_o, 4);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_resp_result", resp_result_o, 0);
    step();
    req_valid_i = 1'b0; unit_in_ready_i = 1'b0; rst_ni = 1'b1;

    // Single op, returned three cycles after issue
    step(); req_valid_i = 1'b1; unit_in_ready_i = 1'b1;
    step(); req_valid_i = 1'b0;
    chk("single_credits_issue", credits_o, 3);
    step();
    step(); unit_valid_i = 1'b1; unit_result_i = 32'h48E00000; unit_status_i = 5'd0; unit_tag_i = 1'b1;
    chk("single_credits_inflight", credits_o, 3);
    step(); unit_valid_i = 1'b0;
    chk("single_resp_valid", resp_valid_o, 1);
    chk("single_resp_result", resp_result_o, 32'h48E00000);
    chk("single_resp_tag", resp_tag_o, 1);
    chk("single_credits_push", credits_o, 3);
    resp_ready_i = 1'b1;
    step(); resp_ready_i = 1'b0;
    chk("single_credits_pop", credits_o, 4);
    chk("single_busy_pop", busy_o, 0);

    // Credit stall
    req_valid_i = 1'b1;
    repeat (4) step();
    chk("stall_req_ready", req_ready_o, 0);
    chk("stall_unit_in_valid", unit_in_valid_o, 0);
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      unit_valid_i = 1'b1; unit_result_i = 32'(32'h10 + i); unit_status_i = 5'(i); unit_tag_i = 1'(i);
      step();
    end
    unit_valid_i = 1'b0; req_valid_i = 1'b1;
    chk("stall_full_req_ready", req_ready_o, 0);
    resp_ready_i = 1'b1;
    step(); resp_ready_i = 1'b0;
    chk("stall_release_req_ready", req_ready_o, 1);
    req_valid_i = 1'b0;

    // Refill to full with nothing outstanding, then force an illegal result during a pop
    req_valid_i = 1'b1;
    step(); req_valid_i = 1'b0;
    step(); unit_valid_i = 1'b1; unit_result_i = 32'h14; unit_status_i = 5'd4; unit_tag_i = 1'b0;
    step(); unit_valid_i = 1'b0;
    chk("full_credits", credits_o, 0);
    unit_valid_i = 1'b1; unit_result_i = 32'hBAD; resp_ready_i = 1'b1;
    #1;
    chk("full_unit_ready", unit_ready_o, 0);
    step(); unit_valid_i = 1'b0; resp_ready_i = 1'b0;
    chk("full_overflow", overflow_o, 1);
    repeat (3) step();
    chk("full_overflow_sticky", overflow_o, 1);
    resp_ready_i = 1'b1;
    repeat (3) step();
    resp_ready_i = 1'b0;
    chk("drain_resp_valid", resp_valid_o, 0);

    // Flush with two stored, one outstanding, one result on the wire
    req_valid_i = 1'b1;
    repeat (3) step();
    req_valid_i = 1'b0;
    unit_valid_i = 1'b1; unit_result_i = 32'h20; unit_tag_i = 1'b0;
    step(); unit_result_i = 32'h21; unit_tag_i = 1'b1;
    step(); unit_result_i = 32'h22; unit_tag_i = 1'b0; flush_i = 1'b1;
    step(); flush_i = 1'b0; unit_valid_i = 1'b0;
    chk("flush_resp_valid", resp_valid_o, 0);
    chk("flush_busy", busy_o, 0);
    chk("flush_credits", credits_o, 4);

    // Wrap and order: ten ops, random backpressure on both sides
    issued = 0; returned = 0; cyc = 0; iss_flag = 0; ret_flag = 0;
    while (popped_r.size() < 16 && cyc < 400) begin
      step();
      cyc++;
      if (iss_flag) issued++;
      if (ret_flag) returned++;
      req_valid_i     = (issued < 10);
      unit_in_ready_i = 1'($urandom_range(0, 1));
      unit_valid_i    = (returned < issued);
      unit_result_i   = 32'(returned + 1);
      unit_status_i   = 5'(returned + 1);
      unit_tag_i      = 1'(returned);
      resp_ready_i    = 1'($urandom_range(0, 1));
      #1;
      iss_flag = unit_in_valid_o && unit_in_ready_i;
      ret_flag = unit_valid_i && unit_ready_o;
    end
    req_valid_i = 1'b0; unit_valid_i = 1'b0; resp_ready_i = 1'b0;
    step();

    exp_r = '{32'h48E00000, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14,
              32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    exp_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    chk("popped_count", popped_r.size(), 16);
    for (int i = 0; i < 16 && i < popped_r.size(); i++) begin
      chk($sformatf("order_result[%0d]", i), popped_r[i], exp_r[i]);
      chk($sformatf("order_tag[%0d]", i), popped_t[i], exp_t[i]);
    end
    chk("end_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
